// File: rtl/reduce_tree_pipe.sv
// reduce_tree_pipe
//   Pipelined N-port logic reduction engine. It combines PORT_NUM operands of
//   WIDTH bits with AND, OR or XOR through a registered binary tree, and
//   returns either the lane-wise (bitwise) result or a 1-bit full reduction
//   that is zero-extended into out_data[0]. A valid/ready handshake runs on
//   both sides. The whole pipeline stalls together while the output holds a
//   result that downstream has not taken.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; drops every in-flight beat
//   in_valid   operand set valid
//   in_ready   engine accepts an operand set this cycle (combinational)
//   in_data    packed operands, port k = in_data[k*WIDTH +: WIDTH]
//   in_mask    1 = port participates, 0 = port replaced by the identity
//   in_op      00 AND, 01 OR, 10 XOR, 11 treated as AND
//   in_mode    0 bitwise result, 1 full reduction to one bit
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result, forced to zero while out_valid is low
module reduce_tree_pipe #(
  parameter int PORT_NUM = 8,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PORT_NUM*WIDTH-1:0] in_data,
  input  logic [PORT_NUM-1:0]       in_mask,
  input  logic [1:0]                in_op,
  input  logic                      in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data
);

  localparam int LEVELS = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 0;
  localparam int P2     = 1 << LEVELS;
  // All tree stages live in one flat node array: stage s holds P2>>s nodes
  // starting at base(s), so the array has exactly 2*P2-1 entries.
  localparam int NODES  = 2 * P2 - 1;

  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  function automatic int base(input int s);
    return 2 * P2 - ((2 * P2) >> s);
  endfunction

  function automatic logic [WIDTH-1:0] ident(input logic [1:0] op);
    return (op == OP_OR || op == OP_XOR) ? '0 : '1;
  endfunction

  function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic reduce_bits(input logic [1:0] op,
                                       input logic [WIDTH-1:0] v);
    case (op)
      OP_OR:   return |v;
      OP_XOR:  return ^v;
      default: return &v;
    endcase
  endfunction

  logic [WIDTH-1:0]    node_q [NODES];
  logic [WIDTH-1:0]    node_d [NODES];
  logic [LEVELS:0]     valid_q;
  logic [1:0]          op_q [LEVELS+1];
  logic [LEVELS:0]     mode_q;
  logic                advance;
  logic [P2*WIDTH-1:0] data_pad;
  logic [P2-1:0]       mask_pad;
  logic [WIDTH-1:0]    lane;

  assign out_valid = valid_q[LEVELS];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign lane      = node_q[NODES-1];

  // Padding ports get mask=0 so they collapse to the identity like any
  // masked port.
  always_comb begin
    data_pad = '0;
    data_pad[PORT_NUM*WIDTH-1:0] = in_data;
    mask_pad = '0;
    mask_pad[PORT_NUM-1:0] = in_mask;
  end

  always_comb begin
    for (int k = 0; k < P2; k++) begin
      node_d[k] = mask_pad[k] ? data_pad[k*WIDTH +: WIDTH] : ident(in_op);
    end
    // Each stage combines node pairs using the op that travelled with them.
    for (int s = 1; s <= LEVELS; s++) begin
      for (int k = 0; k < (P2 >> s); k++) begin
        node_d[base(s) + k] = combine(op_q[s-1],
                                      node_q[base(s-1) + 2*k],
                                      node_q[base(s-1) + 2*k + 1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int s = 1; s <= LEVELS; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Data, op and mode need no reset; out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (advance) begin
      node_q    <= node_d;
      op_q[0]   <= in_op;
      mode_q[0] <= in_mode;
      for (int s = 1; s <= LEVELS; s++) begin
        op_q[s]   <= op_q[s-1];
        mode_q[s] <= mode_q[s-1];
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      if (mode_q[LEVELS]) begin
        out_data[0] = reduce_bits(op_q[LEVELS], lane);
      end else begin
        out_data = lane;
      end
    end
  end

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Bench for reduce_tree_pipe. Three instances (PORT_NUM 8, 5 and 1, WIDTH 7)
// share one set of inputs. Each instance sees the low ports of the shared
// operand bus. Expected results come from a sequential fold over the ports.
module tb_reduce_tree_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        in_mode;
  logic [1:0]  in_op;
  logic [55:0] in_data;
  logic [7:0]  in_mask;
  logic        ir [3];
  logic        ov [3];
  logic [6:0]  od [3];

  int checks   = 0;
  int failures = 0;
  int np  [3] = '{8, 5, 1};
  int dep [3] = '{4, 4, 1};

  int         lat_r [3];
  int         nout_r [3];
  logic [6:0] res_r [3];

  always #5 clk = ~clk;

  reduce_tree_pipe #(.PORT_NUM(8), .WIDTH(7)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_mask(in_mask), .in_op(in_op), .in_mode(in_mode),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));

  reduce_tree_pipe #(.PORT_NUM(5), .WIDTH(7)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data[34:0]), .in_mask(in_mask[4:0]), .in_op(in_op), .in_mode(in_mode),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));

  reduce_tree_pipe #(.PORT_NUM(1), .WIDTH(7)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data[6:0]), .in_mask(in_mask[0:0]), .in_op(in_op), .in_mode(in_mode),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));

  function automatic logic [6:0] model(input logic [55:0] d, input logic [7:0] m,
                                       input int n, input logic [1:0] op, input logic mode);
    logic [6:0] acc;
    logic [6:0] x;
    logic       r;
    acc = (op == 2'b01 || op == 2'b10) ? 7'h00 : 7'h7F;
    for (int k = 0; k < n; k++) begin
      if (m[k]) begin
        x = d[k*7 +: 7];
        case (op)
          2'b01:   acc = acc | x;
          2'b10:   acc = acc ^ x;
          default: acc = acc & x;
        endcase
      end
    end
    if (!mode) return acc;
    case (op)
      2'b01:   r = |acc;
      2'b10:   r = ^acc;
      default: r = &acc;
    endcase
    return {6'b0, r};
  endfunction

  function automatic logic [55:0] rand56();
    return {24'($urandom), $urandom};
  endfunction

  // Sends one beat into the idle engines and watches 12 cycles, recording
  // per instance the latency of the first result, its data and the result count.
  task automatic single_beat(input logic [55:0] d, input logic [7:0] m,
                             input logic [1:0] op, input logic mode);
    @(negedge clk);
    in_data = d; in_mask = m; in_op = op; in_mode = mode;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lat_r[i] = 0; nout_r[i] = 0; res_r[i] = '0;
    end
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (nout_r[i] == 0) begin
            lat_r[i] = c;
            res_r[i] = od[i];
          end
          nout_r[i]++;
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mask = '0; in_op = '0; in_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 7'h00) begin
        failures++;
        $display("FAIL reset_out dut%0d: out_valid=%b out_data=%h, want 0/00", i, ov[i], od[i]);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready dut%0d: in_ready=%b, want 1", i, ir[i]);
      end
    end
  endtask

  task automatic test_and_full();
    logic [55:0] d;
    logic [7:0]  m;
    logic [6:0]  exp8;
    logic [6:0]  e;
    for (int c = 0; c < 3; c++) begin
      d = '1; m = 8'hFF; exp8 = 7'h01;
      if (c >= 1) d[3*7 +: 7] = 7'h7E;
      if (c == 1) exp8 = 7'h00;
      if (c == 2) m = 8'hF7;
      single_beat(d, m, 2'b00, 1'b1);
      checks++;
      if (res_r[0] !== exp8) begin
        failures++;
        $display("FAIL and_full_spec case%0d: out_data=%h, want %h", c, res_r[0], exp8);
      end
      for (int i = 0; i < 3; i++) begin
        e = model(d, m, np[i], 2'b00, 1'b1);
        checks++;
        if (res_r[i] !== e || lat_r[i] != dep[i] || nout_r[i] != 1) begin
          failures++;
          $display("FAIL and_full case%0d dut%0d: data=%h lat=%0d count=%0d, want data=%h lat=%0d count=1",
                   c, i, res_r[i], lat_r[i], nout_r[i], e, dep[i]);
        end
      end
    end
  endtask

  task automatic test_bitwise();
    logic [55:0] d;
    logic [1:0]  op;
    logic        mode;
    logic [6:0]  exp8;
    logic [6:0]  e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin d = '1; d[6:0] = 7'h0F; op = 2'b00; mode = 1'b0; exp8 = 7'h0F; end
        1: begin
          for (int k = 0; k < 8; k++) d[k*7 +: 7] = 7'(k + 1);
          op = 2'b10; mode = 1'b0; exp8 = 7'h08;
        end
        default: begin d = '0; op = 2'b01; mode = 1'b1; exp8 = 7'h00; end
      endcase
      single_beat(d, 8'hFF, op, mode);
      checks++;
      if (res_r[0] !== exp8) begin
        failures++;
        $display("FAIL bitwise_spec case%0d: out_data=%h, want %h", c, res_r[0], exp8);
      end
      for (int i = 0; i < 3; i++) begin
        e = model(d, 8'hFF, np[i], op, mode);
        checks++;
        if (res_r[i] !== e || lat_r[i] != dep[i] || nout_r[i] != 1) begin
          failures++;
          $display("FAIL bitwise case%0d dut%0d: data=%h lat=%0d count=%0d, want data=%h lat=%0d count=1",
                   c, i, res_r[i], lat_r[i], nout_r[i], e, dep[i]);
        end
      end
    end
  endtask

  task automatic test_all_masked();
    logic [55:0] d;
    logic [1:0]  op;
    logic        mode;
    logic [6:0]  exp_all;
    for (int c = 0; c < 4; c++) begin
      d = rand56();
      case (c)
        0:       begin op = 2'b00; mode = 1'b0; exp_all = 7'h7F; end
        1:       begin op = 2'b10; mode = 1'b1; exp_all = 7'h00; end
        2:       begin op = 2'b00; mode = 1'b1; exp_all = 7'h01; end
        default: begin op = 2'b01; mode = 1'b0; exp_all = 7'h00; end
      endcase
      single_beat(d, 8'h00, op, mode);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res_r[i] !== exp_all || lat_r[i] != dep[i] || nout_r[i] != 1) begin
          failures++;
          $display("FAIL all_masked case%0d dut%0d: data=%h lat=%0d count=%0d, want data=%h lat=%0d count=1",
                   c, i, res_r[i], lat_r[i], nout_r[i], exp_all, dep[i]);
        end
      end
    end
  endtask

  // Ten beats into the 8-port engine while downstream stalls in cycles 3-7.
  task automatic test_back_to_back();
    logic [6:0] q [$];
    logic [6:0] held;
    logic [6:0] e;
    int  sent = 0;
    int  got = 0;
    bit  holding = 0;
    bit  saw_stall = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 7);
      if (sent < 10) begin
        in_valid = 1'b1; in_data = rand56(); in_mask = 8'($urandom);
        in_op = 2'($urandom); in_mode = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (holding) begin
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== held) begin
          failures++;
          $display("FAIL b2b_hold cyc%0d: out_valid=%b out_data=%h, want 1/%h", cyc, ov[0], od[0], held);
        end
      end
      if (!out_ready && ov[0] && !ir[0]) saw_stall = 1;
      if (in_valid && ir[0]) begin
        q.push_back(model(in_data, in_mask, 8, in_op, in_mode));
        sent++;
      end
      if (ov[0] && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra cyc%0d: out_data=%h, want no result", cyc, od[0]);
        end else begin
          e = q.pop_front();
          if (od[0] !== e) begin
            failures++;
            $display("FAIL b2b_data beat%0d: out_data=%h, want %h", got, od[0], e);
          end
        end
        got++;
      end
      holding = ov[0] && !out_ready;
      held = od[0];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (sent != 10 || got != 10 || q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: sent=%0d received=%0d pending=%0d, want 10/10/0", sent, got, q.size());
    end
    checks++;
    if (!saw_stall || ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready: dropped=%0d recovered=%b, want 1/1", saw_stall, ir[0]);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    bit stale [3];
    @(negedge clk);
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_data = '1; in_mask = 8'hFF; in_op = 2'b00; in_mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 7'h00 || ir[i] !== 1'b1) begin
        failures++;
        $display("FAIL midreset dut%0d: out_valid=%b out_data=%h in_ready=%b, want 0/00/1",
                 i, ov[i], od[i], ir[i]);
      end
      stale[i] = 0;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (ov[i]) stale[i] = 1;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stale[i]) begin
        failures++;
        $display("FAIL midreset_stale dut%0d: result after reset=1, want 0", i);
      end
    end
  endtask

  // Random valid/ready traffic on all three engines with a per-engine queue.
  task automatic test_random();
    logic [6:0] q0 [$];
    logic [6:0] q1 [$];
    logic [6:0] q2 [$];
    logic [6:0] e;
    logic [6:0] held [3];
    bit   holding [3];
    int   got [3];
    int   bad = 0;
    int   qs;
    for (int i = 0; i < 3; i++) begin holding[i] = 0; got[i] = 0; end
    for (int cyc = 0; cyc < 260; cyc++) begin
      @(negedge clk);
      if (cyc < 240) begin
        in_valid = ($urandom_range(0, 9) < 7); out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      in_data = rand56(); in_mask = 8'($urandom);
      in_op = 2'($urandom); in_mode = 1'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (holding[i]) begin
          checks++;
          if (ov[i] !== 1'b1 || od[i] !== held[i]) begin
            failures++;
            $display("FAIL rnd_hold dut%0d cyc%0d: out_valid=%b out_data=%h, want 1/%h", i, cyc, ov[i], od[i], held[i]);
          end
        end
        if (!ov[i] && od[i] !== 7'h00) bad++;
        if (in_valid && ir[i]) begin
          e = model(in_data, in_mask, np[i], in_op, in_mode);
          case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
          endcase
        end
        if (ov[i] && out_ready) begin
          case (i)
            0: qs = q0.size();
            1: qs = q1.size();
            default: qs = q2.size();
          endcase
          checks++;
          if (qs == 0) begin
            failures++;
            $display("FAIL rnd_extra dut%0d cyc%0d: out_data=%h, want no result", i, cyc, od[i]);
          end else begin
            case (i)
              0: e = q0.pop_front();
              1: e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            if (od[i] !== e) begin
              failures++;
              $display("FAIL rnd_data dut%0d beat%0d: out_data=%h, want %h", i, got[i], od[i], e);
            end
          end
          got[i]++;
        end
        holding[i] = ov[i] && !out_ready;
        held[i] = od[i];
      end
      @(posedge clk);
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL rnd_lost: pending=%0d/%0d/%0d, want 0/0/0", q0.size(), q1.size(), q2.size());
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rnd_idle_zero: nonzero idle out_data cycles=%0d, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_and_full();
    test_bitwise();
    test_all_masked();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
